ram_arbiter: RTL and testbench

- Shares one synchronous-read data RAM (1-cycle read latency, one write port, one read port, no byte enables) between the core's instruction-fetch port and load/store port.
- Arbitrates between the two ports round-robin.
- Sequences each access into RAM strobes and returns read data.
- Gives the load/store port byte-strobe writes by performing read-modify-write on the word-wide RAM.

---
 rtl/ram_arbiter.sv | 156 +++++++++++++++
 tb/tb_ram_arbiter.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one synchronous-read, word-wide RAM between an instruction-fetch port and a
// load/store port with round-robin arbitration; partial-strobe stores become read-modify-write.
module ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 256,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [DATA_WIDTH-1:0] i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [STRB_WIDTH-1:0] d_req_wstrb,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [DATA_WIDTH-1:0] d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  // Handshake: a request transfers in the cycle where valid & ready are both high;
  // ready is only offered in IDLE and never to both ports at once. Responses are
  // single-cycle pulses with no back-pressure.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_RSP = 2'd1,
    RMW_WR = 2'd2,
    ACK    = 2'd3
  } state_t;

  state_t                state;
  state_t                next_state;
  logic                  d_prio;     // 1: d port wins the next contention
  logic                  rsp_to_d;   // owner of the pending read response
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [STRB_WIDTH-1:0] lat_wstrb;
  logic                  grant_i;
  logic                  grant_d;
  logic [DATA_WIDTH-1:0] merged;

  assign i_req_ready = grant_i;
  assign d_req_ready = grant_d;

  always_comb begin
    merged = ram_rdata;
    for (int k = 0; k < STRB_WIDTH; k++) begin
      if (lat_wstrb[k]) begin
        merged[8*k +: 8] = lat_wdata[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_prio    <= 1'b1;
      rsp_to_d  <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_wstrb <= '0;
    end else begin
      state <= next_state;
      if (grant_i) begin
        d_prio   <= 1'b1;
        rsp_to_d <= 1'b0;
      end
      if (grant_d) begin
        d_prio    <= 1'b0;
        rsp_to_d  <= 1'b1;
        lat_addr  <= d_req_addr;
        lat_wdata <= d_req_wdata;
        lat_wstrb <= d_req_wstrb;
      end
    end
  end

  always_comb begin
    next_state  = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_data  = '0;
    d_rsp_valid = 1'b0;
    d_rsp_data  = '0;
    ram_wen     = 1'b0;
    ram_ren     = 1'b0;
    ram_waddr   = '0;
    ram_raddr   = '0;
    ram_wdata   = '0;
    case (state)
      IDLE: begin
        // rst gating keeps ready and RAM strobes low while reset is held
        if (!rst) begin
          grant_d = d_req_valid && (!i_req_valid || d_prio);
          grant_i = i_req_valid && !grant_d;
        end
        if (grant_i) begin
          ram_ren    = 1'b1;
          ram_raddr  = i_req_addr;
          next_state = RD_RSP;
        end else if (grant_d) begin
          if (!d_req_we) begin
            ram_ren    = 1'b1;
            ram_raddr  = d_req_addr;
            next_state = RD_RSP;
          end else if (&d_req_wstrb) begin
            ram_wen    = 1'b1;
            ram_waddr  = d_req_addr;
            ram_wdata  = d_req_wdata;
            next_state = ACK;
          end else if (|d_req_wstrb) begin
            ram_ren    = 1'b1;
            ram_raddr  = d_req_addr;
            next_state = RMW_WR;
          end else begin
            next_state = ACK;
          end
        end
      end
      RD_RSP: begin
        if (rsp_to_d) begin
          d_rsp_valid = 1'b1;
          d_rsp_data  = ram_rdata;
        end else begin
          i_rsp_valid = 1'b1;
          i_rsp_data  = ram_rdata;
        end
        next_state = IDLE;
      end
      RMW_WR: begin
        ram_wen    = 1'b1;
        ram_waddr  = lat_addr;
        ram_wdata  = merged;
        next_state = ACK;
      end
      ACK: begin
        d_rsp_valid = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, directed scenarios, and randomized traffic
// checked against a memory/arbitration reference model.
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_req_valid = 1'b0;
  logic          i_req_ready;
  logic [AW-1:0] i_req_addr = '0;
  logic          i_rsp_valid;
  logic [DW-1:0] i_rsp_data;
  logic          d_req_valid = 1'b0;
  logic          d_req_ready;
  logic          d_req_we = 1'b0;
  logic [SW-1:0] d_req_wstrb = '0;
  logic [AW-1:0] d_req_addr = '0;
  logic [DW-1:0] d_req_wdata = '0;
  logic          d_rsp_valid;
  logic [DW-1:0] d_rsp_data;
  logic          ram_wen;
  logic          ram_ren;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic [DW-1:0] mem [256];
  logic [DW-1:0] ref_mem [16];
  bit            d_next;
  int            checks = 0;
  int            errors = 0;

  ram_arbiter #(.DATA_WIDTH(DW), .MEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_wstrb(d_req_wstrb), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // clock / reset block and the RAM behind the arbiter
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_ren) ram_rdata <= mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // driver: one d-port transaction; lat = cycles accept->rsp, -1 when no response arrives
  task automatic d_op(input logic we, input logic [SW-1:0] strb, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output logic [DW-1:0] rdata, output int lat);
    int n;
    d_req_valid = 1'b1; d_req_we = we; d_req_wstrb = strb;
    d_req_addr = addr; d_req_wdata = wdata;
    n = 0;
    #1;
    while (!d_req_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk);
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    lat = -1;
    rdata = '0;
    for (int k = 1; k <= 4; k++) begin
      if (d_rsp_valid) begin
        lat = k; rdata = d_rsp_data;
        break;
      end
      @(negedge clk); #1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    i_req_valid = 1'b1; d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'hF;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, ram_wen, ram_ren} !== 6'b0 ||
        i_rsp_data !== '0 || d_rsp_data !== '0 || ram_waddr !== '0 || ram_raddr !== '0 ||
        ram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b%b rsp=%b%b wen=%b ren=%b, required all 0",
               i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, ram_wen, ram_ren);
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    logic [DW-1:0] rd;
    int lat;
    d_op(1'b1, 4'hF, 8'd5, 32'hDEADBEEF, rd, lat);
    checks++;
    if (lat !== 1) begin errors++; $display("FAIL preload5_lat: got %0d required 1", lat); end
    i_req_valid = 1'b1; i_req_addr = 8'd5;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, ram_ren, ram_wen} !== 4'b1010 || ram_raddr !== 8'd5) begin
      errors++;
      $display("FAIL fetch_accept: got irdy=%b drdy=%b ren=%b wen=%b raddr=%0d required 1,0,1,0,5",
               i_req_ready, d_req_ready, ram_ren, ram_wen, ram_raddr);
    end
    @(posedge clk); @(negedge clk);
    i_req_valid = 1'b0;
    #1;
    checks++;
    if (i_rsp_valid !== 1'b1 || i_rsp_data !== 32'hDEADBEEF || d_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_rsp: got v=%b data=%h dv=%b required 1 deadbeef 0",
               i_rsp_valid, i_rsp_data, d_rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (i_rsp_valid !== 1'b0 || i_rsp_data !== '0) begin
      errors++;
      $display("FAIL fetch_pulse: got v=%b data=%h required 0 0", i_rsp_valid, i_rsp_data);
    end
  endtask

  task automatic test_full_store_load();
    logic [DW-1:0] rd;
    int lat;
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'hF;
    d_req_addr = 8'd10; d_req_wdata = 32'h12345678;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || ram_wen !== 1'b1 || ram_ren !== 1'b0 ||
        ram_waddr !== 8'd10 || ram_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL full_store_accept: got rdy=%b wen=%b ren=%b waddr=%0d wdata=%h required 1 1 0 10 12345678",
               d_req_ready, ram_wen, ram_ren, ram_waddr, ram_wdata);
    end
    @(posedge clk); @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== '0 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL full_store_ack: got v=%b data=%h wen=%b required 1 0 0", d_rsp_valid, d_rsp_data, ram_wen);
    end
    @(negedge clk);
    d_op(1'b0, 4'h0, 8'd10, 32'h0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'h12345678) begin
      errors++;
      $display("FAIL load10: got lat=%0d data=%h required 1 12345678", lat, rd);
    end
  endtask

  task automatic test_partial();
    logic [DW-1:0] rd;
    int lat;
    d_op(1'b1, 4'hF, 8'd3, 32'hAABBCCDD, rd, lat);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'b0101;
    d_req_addr = 8'd3; d_req_wdata = 32'h11223344;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || ram_ren !== 1'b1 || ram_raddr !== 8'd3 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL partial_accept: got rdy=%b ren=%b raddr=%0d wen=%b required 1 1 3 0",
               d_req_ready, ram_ren, ram_raddr, ram_wen);
    end
    @(posedge clk); @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    checks++;
    if (ram_wen !== 1'b1 || ram_waddr !== 8'd3 || ram_wdata !== 32'hAA22CC44 || d_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL partial_write: got wen=%b waddr=%0d wdata=%h dv=%b required 1 3 aa22cc44 0",
               ram_wen, ram_waddr, ram_wdata, d_rsp_valid);
    end
    @(negedge clk); #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== '0 || ram_wen !== 1'b0) begin
      errors++;
      $display("FAIL partial_ack: got v=%b data=%h wen=%b required 1 0 0", d_rsp_valid, d_rsp_data, ram_wen);
    end
    @(negedge clk);
    d_op(1'b0, 4'h0, 8'd3, 32'h0, rd, lat);
    checks++;
    if (lat !== 1 || rd !== 32'hAA22CC44) begin
      errors++;
      $display("FAIL load3: got lat=%0d data=%h required 1 aa22cc44", lat, rd);
    end
  endtask

  task automatic test_zero_strobe();
    logic [DW-1:0] rd;
    int lat;
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'h0;
    d_req_addr = 8'd10; d_req_wdata = 32'hFFFFFFFF;
    #1;
    checks++;
    if (d_req_ready !== 1'b1 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL zero_accept: got rdy=%b wen=%b ren=%b required 1 0 0", d_req_ready, ram_wen, ram_ren);
    end
    @(posedge clk); @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    checks++;
    if (d_rsp_valid !== 1'b1 || d_rsp_data !== '0 || ram_wen !== 1'b0 || ram_ren !== 1'b0) begin
      errors++;
      $display("FAIL zero_ack: got v=%b data=%h wen=%b ren=%b required 1 0 0 0",
               d_rsp_valid, d_rsp_data, ram_wen, ram_ren);
    end
    @(negedge clk);
    d_op(1'b0, 4'h0, 8'd10, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h12345678) begin
      errors++;
      $display("FAIL zero_unchanged: got %h required 12345678", rd);
    end
  endtask

  task automatic test_reset_mid_rmw();
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_wstrb = 4'b0001;
    d_req_addr = 8'd3; d_req_wdata = 32'h000000FF;
    @(posedge clk); @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    checks++;
    if (ram_wen !== 1'b1) begin
      errors++;
      $display("FAIL rmw_reached: got wen=%b required 1", ram_wen);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, ram_wen, ram_ren} !== 6'b0 ||
        ram_waddr !== '0 || ram_wdata !== '0 || d_rsp_data !== '0) begin
      errors++;
      $display("FAIL rmw_reset_outputs: got rdy=%b%b rsp=%b%b wen=%b ren=%b required all 0",
               i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, ram_wen, ram_ren);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (mem[3] !== 32'hAA22CC44 || d_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rmw_reset_mem: got mem=%h dv=%b required aa22cc44 0", mem[3], d_rsp_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit exp_d;
    logic [DW-1:0] exp_data;
    exp_d = 1'b1;
    i_req_addr = 8'd5;
    d_req_we = 1'b0; d_req_addr = 8'd10;
    for (int n = 0; n < 4; n++) begin
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      #1;
      checks++;
      if (d_req_ready !== exp_d || i_req_ready !== !exp_d) begin
        errors++;
        $display("FAIL contention_grant%0d: got irdy=%b drdy=%b required d=%b", n, i_req_ready, d_req_ready, exp_d);
      end
      @(posedge clk); @(negedge clk);
      if (exp_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
      #1;
      exp_data = exp_d ? 32'h12345678 : 32'hDEADBEEF;
      checks++;
      if (d_rsp_valid !== exp_d || i_rsp_valid !== !exp_d ||
          (exp_d ? d_rsp_data : i_rsp_data) !== exp_data) begin
        errors++;
        $display("FAIL contention_rsp%0d: got iv=%b dv=%b idata=%h ddata=%h required d=%b data=%h",
                 n, i_rsp_valid, d_rsp_valid, i_rsp_data, d_rsp_data, exp_d, exp_data);
      end
      @(negedge clk);
      exp_d = !exp_d;
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [DW-1:0] rd;
    logic [DW-1:0] exp_data;
    int lat;
    int exp_lat;
    int sel;
    bit exp_d;
    bit exp_i;
    bit got;
    for (int a = 0; a < 16; a++) begin
      ref_mem[a] = $urandom;
      d_op(1'b1, 4'hF, 8'(a), ref_mem[a], rd, lat);
    end
    pulse_reset();
    d_next = 1'b1;
    for (int it = 0; it < 80; it++) begin
      if (!i_req_valid && $urandom_range(0, 1) == 1) begin
        i_req_valid = 1'b1; i_req_addr = 8'($urandom_range(0, 15));
      end
      if (!d_req_valid && $urandom_range(0, 1) == 1) begin
        d_req_valid = 1'b1;
        d_req_we = 1'($urandom_range(0, 1));
        sel = $urandom_range(0, 2);
        d_req_wstrb = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(0, 15));
        d_req_addr = 8'($urandom_range(0, 15));
        d_req_wdata = $urandom;
      end
      if (!i_req_valid && !d_req_valid) begin
        i_req_valid = 1'b1; i_req_addr = 8'($urandom_range(0, 15));
      end
      exp_d = d_req_valid && (!i_req_valid || d_next);
      exp_i = i_req_valid && !exp_d;
      #1;
      checks++;
      if (i_req_ready !== exp_i || d_req_ready !== exp_d) begin
        errors++;
        $display("FAIL rand_grant%0d: got irdy=%b drdy=%b required %b %b", it, i_req_ready, d_req_ready, exp_i, exp_d);
      end
      if (exp_d) begin
        d_next = 1'b0;
        if (!d_req_we) begin
          exp_data = ref_mem[d_req_addr[3:0]]; exp_lat = 1;
        end else begin
          exp_data = '0;
          exp_lat = (d_req_wstrb == 4'h0 || d_req_wstrb == 4'hF) ? 1 : 2;
          for (int b = 0; b < SW; b++)
            if (d_req_wstrb[b]) ref_mem[d_req_addr[3:0]][8*b +: 8] = d_req_wdata[8*b +: 8];
        end
      end else begin
        d_next = 1'b1;
        exp_data = ref_mem[i_req_addr[3:0]]; exp_lat = 1;
      end
      @(posedge clk); @(negedge clk);
      if (exp_d) d_req_valid = 1'b0; else i_req_valid = 1'b0;
      #1;
      got = 1'b0;
      for (int k = 1; k <= 3 && !got; k++) begin
        if (i_rsp_valid || d_rsp_valid) begin
          got = 1'b1;
          checks++;
          if (i_rsp_valid !== !exp_d || d_rsp_valid !== exp_d || k != exp_lat ||
              (exp_d ? d_rsp_data : i_rsp_data) !== exp_data) begin
            errors++;
            $display("FAIL rand_rsp%0d: got iv=%b dv=%b lat=%0d idata=%h ddata=%h required d=%b lat=%0d data=%h",
                     it, i_rsp_valid, d_rsp_valid, k, i_rsp_data, d_rsp_data, exp_d, exp_lat, exp_data);
          end
        end else begin
          checks++;
          if (i_req_ready || d_req_ready) begin
            errors++;
            $display("FAIL rand_busy_ready%0d: got irdy=%b drdy=%b required 0 0", it, i_req_ready, d_req_ready);
          end
          @(negedge clk); #1;
        end
      end
      if (!got) begin
        checks++; errors++;
        $display("FAIL rand_timeout%0d: got no response required one within 3 cycles", it);
      end
      @(negedge clk);
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_full_store_load();
    test_partial();
    test_zero_strobe();
    test_reset_mid_rmw();
    test_contention();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
